aliniere_mantise: RTL and testbench
===================================

Name: aliniere_mantise

Overview:
- Mantissa-alignment stage of the floating-point adder, directly downstream of the exponent-select logic.
- Takes the packed exponent pair and the two 23-bit fractions, and restores the hidden bits.
- Selects the larger-exponent operand, then right-shifts the other mantissa by the exponent difference.
- Uses an iterative 1-bit/cycle shifter with guard/round/sticky bits. Valid/ready handshake on both sides; feeds the mantissa add/sub stage.

Parameters:
- MAX_SHIFT, 26, saturation of the shift count. Any difference >= 26 collapses the mantissa fully into sticky.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept operands
- exponenti  input  16  [15:8] exponent A, [7:0] exponent B
- fractii  input  46  [45:23] fraction A, [22:0] fraction B
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- exponent  output  8  larger exponent (common exponent)
- sel_b  output  1  1 = B is the larger operand (A was shifted); 0 = A larger (B shifted)
- mantisa_mare  output  24  {hidden, fraction} of the larger operand, unshifted
- mantisa_aliniata  output  27  shifted mantissa of the smaller operand: [26:3] mantissa, [2] guard, [1] round, [0] sticky

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset state:
  - state=IDLE, in_ready=1, out_valid=0.
  - exponent, sel_b, mantisa_mare and mantisa_aliniata all 0; internal counter 0.
  - Reset wins over any concurrent handshake, including mid-SHIFT or in DONE; in-flight operands are discarded.
- Hidden bit = OR of that operand's 8 exponent bits: 0 for exponent 0x00, else 1. No denormal exponent adjustment in this stage.
- Operand selection:
  - If expA > expB: sel_b=0, exponent=expA, d=expA-expB; B is shifted.
  - Otherwise (including equal): sel_b=1, exponent=expB, d=expB-expA; A is shifted.
- Shift count cnt = min(d, MAX_SHIFT), 5 bits. Difference computed unsigned on 8 bits, never negative.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid at an edge:
    - register exponent, sel_b and mantisa_mare;
    - load the shift register with {smaller mantissa, 3'b000};
    - load cnt, then go to DONE if cnt==0, else SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle:
    - reg <= {1'b0, reg[26:2], reg[1]|reg[0]} (sticky accumulates every bit shifted out);
    - cnt <= cnt-1;
    - when cnt==1 on this cycle, go to DONE.
  - DONE: out_valid=1, in_ready=0. All outputs held stable while out_ready=0. On out_ready, go to IDLE with out_valid=0 next cycle.
- Latency: out_valid rises cnt+1 cycles after the accepting edge, i.e. 1 cycle for d=0 and 27 cycles maximum.
- Throughput: one operation at a time. No accept in the same cycle as a result handoff; next accept earliest in the cycle after DONE exits.
- Outputs change only on the accept edge or during SHIFT. Output registers are not cleared on handoff.
- in_valid while not IDLE is ignored. The upstream stage holds data until in_ready.

Test Plan:
- Basic: expA=0x82, fracA=0x400000, expB=0x80, fracB=0x000000 -> after 3 cycles out_valid=1, exponent=0x82, sel_b=0, mantisa_mare=0xC00000, mantisa_aliniata=0x1000000.
- Sticky: expA=0x80, fracA=0x000001, expB=0x85, fracB=0 -> latency 6, sel_b=1, exponent=0x85, mantisa_mare=0x800000, mantisa_aliniata=0x0200001.
- Equal exponents: expA=expB=0x7F, fracA=0x200000, fracB=0x100000 -> out_valid 1 cycle after accept, sel_b=1, mantisa_mare=0x900000, mantisa_aliniata=0x5000000.
- Saturation: expA=0xFE, expB=0x01, fracB=0 -> cnt=26, out_valid after 27 cycles, sel_b=0, mantisa_aliniata=0x0000001. Repeat with expB=0xE4 (d=26): identical result.
- Zero exponent / hidden bit: expA=0x00, fracA=0x000010, expB=0x03 -> hidden A=0, mantisa_aliniata=0x0000010 after 3 shifts.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored;
  - assert rst during SHIFT -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/aliniere_mantise.sv
// Mantissa alignment: picks the larger-exponent operand and right-shifts the other 1 bit/cycle with G/R/S.
// Latency cnt+1 cycles (1..27); one op in flight, result held in DONE until out_ready.
module aliniere_mantise #(
   parameter int MAX_SHIFT = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] exponenti,
   input  logic [45:0] fractii,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  exponent,
   output logic        sel_b,
   output logic [23:0] mantisa_mare,
   output logic [26:0] mantisa_aliniata
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [7:0] MAX_D   = 8'(MAX_SHIFT);
   localparam logic [4:0] MAX_CNT = 5'(MAX_SHIFT);

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic [7:0]  exp_a, exp_b, diff;
   logic [23:0] mant_a, mant_b;
   logic        a_mai_mare;
   logic [4:0]  cnt_in;

   assign exp_a      = exponenti[15:8];
   assign exp_b      = exponenti[7:0];
   assign mant_a     = {|exp_a, fractii[45:23]};
   assign mant_b     = {|exp_b, fractii[22:0]};
   assign a_mai_mare = exp_a > exp_b;
   assign diff       = a_mai_mare ? (exp_a - exp_b) : (exp_b - exp_a);
   assign cnt_in     = (diff >= MAX_D) ? MAX_CNT : diff[4:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = (cnt_in == 5'd0) ? DONE : SHIFT;
         end
         SHIFT: begin
            if (cnt == 5'd1) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: loads on accept, shifts in SHIFT, otherwise holds (including after handoff).
   always_ff @(posedge clk) begin
      if (rst) begin
         exponent         <= '0;
         sel_b            <= 1'b0;
         mantisa_mare     <= '0;
         mantisa_aliniata <= '0;
         cnt              <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  exponent         <= a_mai_mare ? exp_a : exp_b;
                  sel_b            <= ~a_mai_mare;
                  mantisa_mare     <= a_mai_mare ? mant_a : mant_b;
                  mantisa_aliniata <= {(a_mai_mare ? mant_b : mant_a), 3'b000};
                  cnt              <= cnt_in;
               end
            end
            SHIFT: begin
               mantisa_aliniata <= {1'b0, mantisa_aliniata[26:2],
                                    mantisa_aliniata[1] | mantisa_aliniata[0]};
               cnt              <= cnt - 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aliniere_mantise.sv
// Directed table-driven bench for aliniere_mantise plus backpressure and mid-shift reset sequences.
module tb_aliniere_mantise;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] exponenti;
   logic [45:0] fractii;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  exponent;
   logic        sel_b;
   logic [23:0] mantisa_mare;
   logic [26:0] mantisa_aliniata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aliniere_mantise #(.MAX_SHIFT(26)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .exponenti(exponenti), .fractii(fractii),
      .out_valid(out_valid), .out_ready(out_ready),
      .exponent(exponent), .sel_b(sel_b),
      .mantisa_mare(mantisa_mare), .mantisa_aliniata(mantisa_aliniata)
   );

   typedef struct {
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb;
      logic [7:0]  x_exp;
      logic        x_sel;
      logic [23:0] x_mare;
      logic [26:0] x_alin;
      int          x_lat;
   } vec_t;

   function automatic vec_t mk(logic [7:0] ea, logic [22:0] fa, logic [7:0] eb, logic [22:0] fb,
                               logic [7:0] xe, logic xs, logic [23:0] xm, logic [26:0] xa, int xl);
      vec_t v;
      v.ea = ea; v.fa = fa; v.eb = eb; v.fb = fb;
      v.x_exp = xe; v.x_sel = xs; v.x_mare = xm; v.x_alin = xa; v.x_lat = xl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept one operand pair at the next edge; returns cycles until out_valid seen.
   task automatic issue(input logic [7:0] ea, input logic [22:0] fa,
                        input logic [7:0] eb, input logic [22:0] fb, output int lat);
      in_valid  = 1'b1;
      exponenti = {ea, eb};
      fractii   = {fa, fb};
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   vec_t vecs[9];
   int   lat;
   logic [7:0]  h_exp;
   logic        h_sel;
   logic [23:0] h_mare;
   logic [26:0] h_alin;

   initial begin
      vecs[0] = mk(8'h82, 23'h400000, 8'h80, 23'h000000, 8'h82, 1'b0, 24'hC00000, 27'h1000000, 3);
      vecs[1] = mk(8'h80, 23'h000001, 8'h85, 23'h000000, 8'h85, 1'b1, 24'h800000, 27'h0200001, 6);
      vecs[2] = mk(8'h7F, 23'h200000, 8'h7F, 23'h100000, 8'h7F, 1'b1, 24'h900000, 27'h5000000, 1);
      vecs[3] = mk(8'hFE, 23'h000000, 8'h01, 23'h000000, 8'hFE, 1'b0, 24'h800000, 27'h0000001, 27);
      vecs[4] = mk(8'hFE, 23'h000000, 8'hE4, 23'h000000, 8'hFE, 1'b0, 24'h800000, 27'h0000001, 27);
      vecs[5] = mk(8'h00, 23'h000010, 8'h03, 23'h000000, 8'h03, 1'b1, 24'h800000, 27'h0000010, 4);
      vecs[6] = mk(8'h81, 23'h000000, 8'h80, 23'h000001, 8'h81, 1'b0, 24'h800000, 27'h2000004, 2);
      vecs[7] = mk(8'h20, 23'h123456, 8'h05, 23'h7FFFFF, 8'h20, 1'b0, 24'h923456, 27'h0000001, 27);
      vecs[8] = mk(8'h00, 23'h000000, 8'h00, 23'h000000, 8'h00, 1'b1, 24'h000000, 27'h0000000, 1);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; exponenti = '0; fractii = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset exponent", 32'(exponent), 32'd0);
      chk("reset mantisa_aliniata", 32'(mantisa_aliniata), 32'd0);

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].ea, vecs[i].fa, vecs[i].eb, vecs[i].fb, lat);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].x_lat));
         chk($sformatf("v%0d exponent", i), 32'(exponent), 32'(vecs[i].x_exp));
         chk($sformatf("v%0d sel_b", i), 32'(sel_b), 32'(vecs[i].x_sel));
         chk($sformatf("v%0d mantisa_mare", i), 32'(mantisa_mare), 32'(vecs[i].x_mare));
         chk($sformatf("v%0d mantisa_aliniata", i), 32'(mantisa_aliniata), 32'(vecs[i].x_alin));
         handoff();
         chk($sformatf("v%0d out_valid after handoff", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d in_ready after handoff", i), 32'(in_ready), 32'd1);
      end
      chk("outputs held after handoff", 32'(mantisa_mare), 32'h0);

      // Backpressure: result held 10 cycles while a new request is presented.
      issue(8'h82, 23'h400000, 8'h80, 23'h000000, lat);
      h_exp = exponent; h_sel = sel_b; h_mare = mantisa_mare; h_alin = mantisa_aliniata;
      in_valid = 1'b1; exponenti = 16'h10_90; fractii = {23'h7FFFFF, 23'h055555};
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp c%0d out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp c%0d in_ready", c), 32'(in_ready), 32'd0);
         chk($sformatf("bp c%0d exponent", c), 32'(exponent), 32'(h_exp));
         chk($sformatf("bp c%0d alin", c), 32'(mantisa_aliniata), 32'(h_alin));
      end
      chk("bp sel_b", 32'(sel_b), 32'(h_sel));
      chk("bp mare", 32'(mantisa_mare), 32'(h_mare));
      in_valid = 1'b0;
      handoff();
      chk("bp released out_valid", 32'(out_valid), 32'd0);
      chk("bp outputs kept", 32'(mantisa_aliniata), 32'h1000000);

      // Reset in the middle of a long shift discards the operation.
      in_valid = 1'b1; exponenti = {8'h94, 8'h80}; fractii = {23'h7FFFFF, 23'h7FFFFF};
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("mid-shift in_ready", 32'(in_ready), 32'd0);
      chk("mid-shift out_valid", 32'(out_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst shift out_valid", 32'(out_valid), 32'd0);
      chk("rst shift in_ready", 32'(in_ready), 32'd1);
      chk("rst shift exponent", 32'(exponent), 32'd0);
      chk("rst shift sel_b", 32'(sel_b), 32'd0);
      chk("rst shift mare", 32'(mantisa_mare), 32'd0);
      chk("rst shift alin", 32'(mantisa_aliniata), 32'd0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("rst shift no late valid", 32'(out_valid), 32'd0);

      issue(vecs[1].ea, vecs[1].fa, vecs[1].eb, vecs[1].fb, lat);
      chk("post-reset latency", 32'(lat), 32'd6);
      chk("post-reset alin", 32'(mantisa_aliniata), 32'h0200001);
      handoff();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
